// File: rtl/sfx_scheduler.sv
// sfx_scheduler
//   Shares one square-wave tone generator among three sound effects
//   (jump, score, death). Rising edges on the request levels are latched as
//   pending bits. In IDLE the highest-priority pending effect (death > score >
//   jump) is granted. While an effect plays, its half-period is reloaded every
//   STEP_CYCLES clocks:
//     - jump:  steps down by JUMP_DELTA
//     - score: halves each step
//     - death: steps up by DEATH_DELTA
//   A death edge preempts a playing jump or score. Every natural finish is
//   followed by a one-cycle GAP with the tone off.
//
//   Each effect spends its *_STEPS steps of STEP_CYCLES clocks at successive
//   periods. The update that follows the last step is still applied, so the
//   held half-period after the effect ends is the next value in the sweep.
//
// Ports
//   CLK100MHZ         in   system clock
//   reset             in   synchronous reset, active high
//   jump              in   jump request level (rising edge requests)
//   score             in   score request level (rising edge requests)
//   isdead            in   death level (rising edge requests)
//   mute              in   forces tone_en low; sequencing is unaffected
//   tone_en           out  tone generator enable (busy & ~mute)
//   tone_half_period  out  half-period in clock cycles
//   active_sfx        out  0 none, 1 jump, 2 score, 3 death
//   busy              out  high while an effect is playing
//   sfx_done          out  one-cycle pulse on natural completion of an effect
module sfx_scheduler #(
  parameter int unsigned STEP_CYCLES = 2500000,
  parameter int unsigned JUMP_START  = 100000,
  parameter int unsigned JUMP_DELTA  = 1280,
  parameter int unsigned JUMP_STEPS  = 8,
  parameter int unsigned SCORE_START = 60000,
  parameter int unsigned SCORE_STEPS = 2,
  parameter int unsigned DEATH_START = 200000,
  parameter int unsigned DEATH_DELTA = 2560,
  parameter int unsigned DEATH_STEPS = 16,
  parameter int unsigned MIN_PERIOD  = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        jump,
  input  logic        score,
  input  logic        isdead,
  input  logic        mute,
  output logic        tone_en,
  output logic [23:0] tone_half_period,
  output logic [1:0]  active_sfx,
  output logic        busy,
  output logic        sfx_done
);

  localparam int unsigned TW = $clog2(STEP_CYCLES);
  localparam int unsigned SW = 16;

  localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [1:0] SFX_NONE  = 2'd0;
  localparam logic [1:0] SFX_JUMP  = 2'd1;
  localparam logic [1:0] SFX_SCORE = 2'd2;
  localparam logic [1:0] SFX_DEATH = 2'd3;

  localparam logic [23:0] MIN_P         = 24'(MIN_PERIOD);
  localparam logic [23:0] JUMP_DELTA_P  = 24'(JUMP_DELTA);
  localparam logic [24:0] DEATH_DELTA_W = 25'(DEATH_DELTA);
  // Below this value a jump subtraction would cross the floor (or underflow).
  localparam logic [24:0] JUMP_FLOOR_W  = 25'(MIN_PERIOD) + 25'(JUMP_DELTA);

  // Request vector order: bit 2 death, bit 1 score, bit 0 jump.
  logic [2:0]    req_q, req_d;
  logic [2:0]    pend_q, pend_d;
  logic [2:0]    fire;
  logic [1:0]    state_q, state_d;
  logic [1:0]    active_q, active_d;
  logic [23:0]   period_q, period_d;
  logic [SW-1:0] steps_q, steps_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          done_q, done_d;

  logic          load_en;
  logic [1:0]    load_sel;
  logic [23:0]   next_period;
  logic [24:0]   death_sum;
  logic [23:0]   score_half;

  assign fire       = {isdead, score, jump} & ~req_q;
  assign death_sum  = {1'b0, period_q} + DEATH_DELTA_W;
  assign score_half = period_q >> 1;

  // Period after one sweep step of the effect currently playing.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; that is what keeps synthesis from inferring a latch.
    next_period = period_q;
    case (active_q)
      SFX_JUMP:  next_period = ({1'b0, period_q} < JUMP_FLOOR_W) ? MIN_P
                                                                 : period_q - JUMP_DELTA_P;
      SFX_SCORE: next_period = (score_half < MIN_P) ? MIN_P : score_half;
      SFX_DEATH: next_period = death_sum[24] ? 24'hFF_FFFF : death_sum[23:0];
      default:   next_period = period_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    req_d    = {isdead, score, jump};
    pend_d   = pend_q | fire;
    active_d = active_q;
    period_d = period_q;
    steps_d  = steps_q;
    timer_d  = timer_q;
    done_d   = 1'b0;
    load_en  = 1'b0;
    load_sel = SFX_NONE;

    case (state_q)
      ST_IDLE: begin
        // Grant from the pending bits registered earlier; an edge arriving in
        // this same cycle is only latched and waits for the next arbitration.
        if (pend_q[2]) begin
          load_en   = 1'b1;
          load_sel  = SFX_DEATH;
          pend_d[2] = fire[2];
        end else if (pend_q[1]) begin
          load_en   = 1'b1;
          load_sel  = SFX_SCORE;
          pend_d[1] = fire[1];
        end else if (pend_q[0]) begin
          load_en   = 1'b1;
          load_sel  = SFX_JUMP;
          pend_d[0] = fire[0];
        end
        if (load_en) state_d = ST_PLAY;
      end

      ST_PLAY: begin
        if (fire[2] && (active_q != SFX_DEATH)) begin
          // Death preempts: the running effect is dropped, not re-queued,
          // and the death edge is consumed rather than left pending.
          load_en   = 1'b1;
          load_sel  = SFX_DEATH;
          pend_d[2] = pend_q[2];
        end else if (timer_q == TIMER_LAST) begin
          timer_d  = '0;
          period_d = next_period;
          if (steps_q == SW'(1)) begin
            state_d  = ST_GAP;
            active_d = SFX_NONE;
            done_d   = 1'b1;
          end else begin
            steps_d = steps_q - SW'(1);
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_GAP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    if (load_en) begin
      active_d = load_sel;
      timer_d  = '0;
      case (load_sel)
        SFX_JUMP: begin
          period_d = 24'(JUMP_START);
          steps_d  = SW'(JUMP_STEPS);
        end
        SFX_SCORE: begin
          period_d = 24'(SCORE_START);
          steps_d  = SW'(SCORE_STEPS);
        end
        default: begin
          period_d = 24'(DEATH_START);
          steps_d  = SW'(DEATH_STEPS);
        end
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      pend_q   <= '0;
      active_q <= SFX_NONE;
      period_q <= '0;
      steps_q  <= '0;
      timer_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      pend_q   <= pend_d;
      active_q <= active_d;
      period_q <= period_d;
      steps_q  <= steps_d;
      timer_q  <= timer_d;
      done_q   <= done_d;
    end
  end

  assign busy             = (state_q == ST_PLAY);
  assign tone_en          = busy & ~mute;
  assign tone_half_period = period_q;
  assign active_sfx       = active_q;
  assign sfx_done         = done_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Testbench for sfx_scheduler. Two instances share all inputs: u_dut uses the
// default sweep shapes, u_arith uses shapes that hit the saturation ceiling and
// the period floor. Both use STEP_CYCLES = 4. A timeline model computes the
// expected outputs from the elapsed time in each effect and closed-form sweep
// arithmetic.
module tb_sfx_scheduler;

  localparam int SC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, jump, score, isdead, mute;

  logic        tone_en, busy, sfx_done;
  logic [23:0] tone_half_period;
  logic [1:0]  active_sfx;
  logic        a_tone_en, a_busy, a_done;
  logic [23:0] a_period;
  logic [1:0]  a_active;

  sfx_scheduler #(.STEP_CYCLES(SC)) u_dut (
    .CLK100MHZ(clk), .reset(reset), .jump(jump), .score(score),
    .isdead(isdead), .mute(mute), .tone_en(tone_en),
    .tone_half_period(tone_half_period), .active_sfx(active_sfx),
    .busy(busy), .sfx_done(sfx_done)
  );

  sfx_scheduler #(
    .STEP_CYCLES(SC), .JUMP_START(3000), .JUMP_DELTA(1500),
    .DEATH_START(32'hFFF000), .DEATH_DELTA(4096)
  ) u_arith (
    .CLK100MHZ(clk), .reset(reset), .jump(jump), .score(score),
    .isdead(isdead), .mute(mute), .tone_en(a_tone_en),
    .tone_half_period(a_period), .active_sfx(a_active),
    .busy(a_busy), .sfx_done(a_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Timeline model: mode 0 idle, 1 playing, 2 gap.
  int          m_mode, m_eff, m_elapsed;
  logic [2:0]  m_pend, m_prev;
  logic        exp_en, exp_busy, exp_done;
  logic [1:0]  exp_active;
  logic [23:0] exp_p0, exp_p1;
  logic [57:0] exp_vec;
  logic [57:0] obs;

  assign obs = {tone_en, busy, active_sfx, sfx_done, tone_half_period,
                a_tone_en, a_busy, a_active, a_done, a_period};

  function automatic int eff_steps(input int eff);
    case (eff)
      1:       return 8;
      2:       return 2;
      default: return 16;
    endcase
  endfunction

  // Half-period after k sweep steps; set 0 = default shapes, 1 = u_arith.
  function automatic logic [23:0] model_period(input int set, input int eff, input int k);
    longint p;
    case (eff)
      1: begin
        p = (set == 0 ? 100000 : 3000) - longint'(k) * (set == 0 ? 1280 : 1500);
        if (p < 1000) p = 1000;
      end
      2: begin
        p = longint'(60000) >> k;
        if (p < 1000) p = 1000;
      end
      3: begin
        p = (set == 0 ? longint'(200000) : longint'(32'hFFF000)) + longint'(k) * (set == 0 ? 2560 : 4096);
        if (p > 64'hFFFFFF) p = 64'hFFFFFF;
      end
      default: p = 0;
    endcase
    return 24'(p);
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic tick(input logic j, input logic s, input logic d, input logic mu, input logic r);
    logic [2:0] ed;
    @(negedge clk);
    jump = j; score = s; isdead = d; mute = mu; reset = r;
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_eff = 0; m_elapsed = 0; m_pend = '0; m_prev = '0;
      exp_done = 1'b0; exp_p0 = '0; exp_p1 = '0;
    end else begin
      ed       = {d, s, j} & ~m_prev;
      m_prev   = {d, s, j};
      exp_done = 1'b0;
      if (m_mode == 1 && ed[2] && m_eff != 3) begin
        m_eff = 3; m_elapsed = 0;
        m_pend = m_pend | (ed & 3'b011);
      end else begin
        if (m_mode == 1) begin
          m_elapsed++;
          if (m_elapsed == eff_steps(m_eff) * SC) begin
            m_mode = 2; exp_done = 1'b1;
          end
        end else if (m_mode == 2) begin
          m_mode = 0;
        end else if (m_pend != 3'b000) begin
          m_eff = m_pend[2] ? 3 : (m_pend[1] ? 2 : 1);
          m_pend[m_eff-1] = 1'b0;
          m_mode = 1; m_elapsed = 0;
        end
        m_pend = m_pend | ed;
      end
      if (m_mode != 0) begin
        exp_p0 = model_period(0, m_eff, m_elapsed / SC);
        exp_p1 = model_period(1, m_eff, m_elapsed / SC);
      end
    end
    exp_busy   = (m_mode == 1);
    exp_active = (m_mode == 1) ? 2'(m_eff) : 2'd0;
    exp_en     = exp_busy & ~mu;
    exp_vec    = {exp_en, exp_busy, exp_active, exp_done, exp_p0,
                  exp_en, exp_busy, exp_active, exp_done, exp_p1};
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL idle_model t=%0t got %h want %h", $time, obs, exp_vec);
      end
    end
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    n_checks++;
    if (obs !== 58'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0", obs);
    end
    tick(0, 0, 0, 0, 0);
    n_checks++;
    if (obs !== 58'd0) begin
      n_fail++;
      $display("FAIL reset_release got %h want 0", obs);
    end
  endtask

  task automatic test_single_jump();
    tick(1, 0, 0, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      tick(i < 3, 0, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL jump_model i=%0d got %h want %h", i, obs, exp_vec);
      end
      if (i == 1) begin
        n_checks++;
        if (busy !== 1'b1 || tone_en !== 1'b1 || tone_half_period !== 24'd100000 || active_sfx !== 2'd1) begin
          n_fail++;
          $display("FAIL jump_grant busy=%b en=%b p=%0d act=%0d want 1 1 100000 1", busy, tone_en, tone_half_period, active_sfx);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (tone_half_period !== 24'd98720) begin
          n_fail++;
          $display("FAIL jump_step1 p=%0d want 98720", tone_half_period);
        end
      end
      if (i == 33) begin
        n_checks++;
        if (sfx_done !== 1'b1 || busy !== 1'b0 || active_sfx !== 2'd0 || tone_en !== 1'b0) begin
          n_fail++;
          $display("FAIL jump_done done=%b busy=%b act=%0d en=%b want 1 0 0 0", sfx_done, busy, active_sfx, tone_en);
        end
      end
      if (i == 36) begin
        n_checks++;
        if (tone_half_period !== 24'd89760 || sfx_done !== 1'b0) begin
          n_fail++;
          $display("FAIL jump_hold p=%0d done=%b want 89760 0", tone_half_period, sfx_done);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int dones;
    dones = 0;
    tick(1, 1, 0, 0, 0);
    for (int i = 1; i <= 50; i++) begin
      tick(0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL simul_model i=%0d got %h want %h", i, obs, exp_vec);
      end
      if (sfx_done === 1'b1) dones++;
      if (i == 1 || i == 5 || i == 9 || i == 11) begin
        n_checks++;
        if ((i == 1  && (active_sfx !== 2'd2 || tone_half_period !== 24'd60000)) ||
            (i == 5  && (active_sfx !== 2'd2 || tone_half_period !== 24'd30000)) ||
            (i == 9  && (sfx_done !== 1'b1 || busy !== 1'b0 || tone_half_period !== 24'd15000)) ||
            (i == 11 && (active_sfx !== 2'd1 || tone_half_period !== 24'd100000))) begin
          n_fail++;
          $display("FAIL simul_seq i=%0d act=%0d p=%0d done=%b busy=%b", i, active_sfx, tone_half_period, sfx_done, busy);
        end
      end
    end
    n_checks++;
    if (dones != 2) begin
      n_fail++;
      $display("FAIL simul_done_count got %0d want 2", dones);
    end
  endtask

  task automatic test_preempt();
    int dones, starts;
    logic [1:0] prev_act;
    dones = 0; starts = 0; prev_act = 2'd0;
    tick(1, 0, 0, 0, 0);
    for (int i = 1; i <= 110; i++) begin
      tick(0, 0, i >= 11, 0, 0);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL preempt_model i=%0d got %h want %h", i, obs, exp_vec);
      end
      if (sfx_done === 1'b1) dones++;
      if (active_sfx === 2'd3 && prev_act !== 2'd3) starts++;
      prev_act = active_sfx;
      if (i == 10) begin
        n_checks++;
        if (active_sfx !== 2'd1 || tone_half_period !== 24'd97440) begin
          n_fail++;
          $display("FAIL preempt_before act=%0d p=%0d want 1 97440", active_sfx, tone_half_period);
        end
      end
      if (i == 11) begin
        n_checks++;
        if (active_sfx !== 2'd3 || tone_half_period !== 24'd200000 || sfx_done !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL preempt_switch act=%0d p=%0d done=%b busy=%b want 3 200000 0 1", active_sfx, tone_half_period, sfx_done, busy);
        end
      end
    end
    n_checks++;
    if (dones != 1 || starts != 1) begin
      n_fail++;
      $display("FAIL preempt_counts done=%0d starts=%0d want 1 1", dones, starts);
    end
    idle(3);
  endtask

  task automatic test_arith();
    tick(0, 0, 1, 0, 0);
    for (int i = 1; i <= 70; i++) begin
      tick(0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL sat_model i=%0d got %h want %h", i, obs, exp_vec);
      end
      if (i == 1 || i == 5 || i == 9 || i == 65) begin
        n_checks++;
        if ((i == 1 && a_period !== 24'hFFF000) || (i != 1 && a_period !== 24'hFFFFFF)) begin
          n_fail++;
          $display("FAIL sat_period i=%0d p=%h want %h", i, a_period, (i == 1) ? 24'hFFF000 : 24'hFFFFFF);
        end
      end
    end
    tick(1, 0, 0, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      tick(0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL floor_model i=%0d got %h want %h", i, obs, exp_vec);
      end
      if (i == 1 || i == 5 || i == 9 || i == 13) begin
        n_checks++;
        if ((i == 1 && a_period !== 24'd3000) || (i == 5 && a_period !== 24'd1500) ||
            (i >= 9 && a_period !== 24'd1000)) begin
          n_fail++;
          $display("FAIL floor_period i=%0d p=%0d", i, a_period);
        end
      end
    end
  endtask

  task automatic test_mute();
    tick(0, 0, 1, 0, 0);
    for (int i = 1; i <= 70; i++) begin
      tick(0, 0, 0, (i >= 3 && i < 21), 0);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL mute_model i=%0d got %h want %h", i, obs, exp_vec);
      end
      if (i == 10) begin
        n_checks++;
        if (tone_en !== 1'b0 || busy !== 1'b1 || tone_half_period !== 24'd205120) begin
          n_fail++;
          $display("FAIL mute_on en=%b busy=%b p=%0d want 0 1 205120", tone_en, busy, tone_half_period);
        end
      end
      if (i == 21) begin
        n_checks++;
        if (tone_en !== 1'b1 || tone_half_period !== 24'd212800) begin
          n_fail++;
          $display("FAIL mute_off en=%b p=%0d want 1 212800", tone_en, tone_half_period);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones, busy_seen;
    dones = 0; busy_seen = 0;
    tick(0, 0, 1, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      tick(i == 10, 0, 0, 0, i == 20);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_model i=%0d got %h want %h", i, obs, exp_vec);
      end
    end
    n_checks++;
    if (obs !== 58'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got %h want 0", obs);
    end
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 0, 0);
      if (busy !== 1'b0 || sfx_done !== 1'b0) busy_seen++;
    end
    n_checks++;
    if (busy_seen != 0) begin
      n_fail++;
      $display("FAIL rstmid_pending_cleared active_cycles=%0d want 0", busy_seen);
    end
    tick(0, 0, 1, 0, 0);
    for (int i = 1; i <= 70; i++) begin
      tick(0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_death_model i=%0d got %h want %h", i, obs, exp_vec);
      end
      if (sfx_done === 1'b1) begin
        dones++;
        n_checks++;
        if (i != 65) begin
          n_fail++;
          $display("FAIL rstmid_done_time i=%0d want 65", i);
        end
      end
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL rstmid_done_count got %0d want 1", dones);
    end
  endtask

  task automatic test_random();
    logic lj, ls, ld, lm, lr;
    lj = 0; ls = 0; ld = 0; lm = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) lj = ~lj;
      if ($urandom_range(0, 29) == 0) ls = ~ls;
      if ($urandom_range(0, 59) == 0) ld = ~ld;
      if ($urandom_range(0, 15) == 0) lm = ~lm;
      lr = ($urandom_range(0, 499) == 0);
      tick(lj, ls, ld, lm, lr);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL random_model i=%0d got %h want %h", i, obs, exp_vec);
      end
    end
  endtask

  initial begin
    reset = 1'b1; jump = 1'b0; score = 1'b0; isdead = 1'b0; mute = 1'b0;
    m_mode = 0; m_eff = 0; m_elapsed = 0; m_pend = '0; m_prev = '0;
    exp_en = 0; exp_busy = 0; exp_done = 0; exp_active = '0;
    exp_p0 = '0; exp_p1 = '0; exp_vec = '0;

    test_reset();
    idle(5);
    test_single_jump();
    idle(3);
    test_simultaneous();
    idle(3);
    test_preempt();
    test_arith();
    idle(3);
    test_mute();
    idle(3);
    test_reset_mid();
    idle(3);
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
